// File: rtl/lcd_line_arbiter_if.sv
// rtl/lcd_line_arbiter_if.sv - client request/text and LCD driver command port bundle for lcd_line_arbiter
interface lcd_line_arbiter_if #(
    parameter int COLS = 16
);
    logic [1:0]          req;
    logic [8*COLS-1:0]   line0;
    logic [8*COLS-1:0]   line1;
    logic [1:0]          done;
    logic                active;
    logic                grant_id;
    logic                lcd_busy;
    logic                lcd_enable;
    logic [9:0]          lcd_bus;
    logic                err;

    modport master (
        input  req, line0, line1, lcd_busy,
        output done, active, grant_id, lcd_enable, lcd_bus, err
    );

    modport slave (
        output req, line0, line1, lcd_busy,
        input  done, active, grant_id, lcd_enable, lcd_bus, err
    );
endinterface

// File: rtl/lcd_line_arbiter.sv
// rtl/lcd_line_arbiter.sv - round-robin two-client line arbiter streaming address+COLS chars to a char LCD; LCD_TIMEOUT_EN adds busy watchdog
module lcd_line_arbiter #(
    parameter int COLS = 16
`ifdef LCD_TIMEOUT_EN
    , parameter int TIMEOUT = 4095
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    lcd_line_arbiter_if.master io
);
    localparam int IW = $clog2(COLS + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE
    } state_t;

    state_t             r_state;
    logic [8*COLS-1:0]  r_buf;
    logic [IW-1:0]      r_idx;
    logic               r_addr_phase;
    logic               r_grant;
    logic               r_active;
    logic [1:0]         r_done;
    logic               r_lcd_enable;
    logic [9:0]         r_lcd_bus;
    logic               w_win;

`ifdef LCD_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 12) ? $clog2(TIMEOUT + 1) : 12;
    logic [CW-1:0]      r_cnt;
    logic               r_err;
    logic               w_expired;
    assign w_expired = (r_cnt == CW'(TIMEOUT));
    assign io.err    = r_err;
`else
    assign io.err    = 1'b0;
`endif

    // On a tie the client that was not served last wins.
    always_comb begin
        w_win = io.req[1];
        if (io.req == 2'b11)
            w_win = ~r_grant;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_buf        <= '0;
            r_idx        <= '0;
            r_addr_phase <= 1'b1;
            r_grant      <= 1'b1;
            r_active     <= 1'b0;
            r_done       <= 2'b00;
            r_lcd_enable <= 1'b0;
            r_lcd_bus    <= 10'h000;
`ifdef LCD_TIMEOUT_EN
            r_cnt        <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            r_lcd_enable <= 1'b0;
            r_done       <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|io.req) begin
                        r_buf        <= w_win ? io.line1 : io.line0;
                        r_grant      <= w_win;
                        r_active     <= 1'b1;
                        r_addr_phase <= 1'b1;
                        r_idx        <= '0;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!io.lcd_busy) begin
                        r_lcd_enable <= 1'b1;
                        r_lcd_bus    <= r_addr_phase ? {2'b00, (r_grant ? 8'hC0 : 8'h80)}
                                                     : {2'b10, r_buf[7:0]};
`ifdef LCD_TIMEOUT_EN
                        r_cnt        <= '0;
`endif
                        r_state      <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
`ifdef LCD_TIMEOUT_EN
                    if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else if (io.lcd_busy) begin
                        r_cnt   <= '0;
                        r_state <= WAIT_LO;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
`else
                    if (io.lcd_busy)
                        r_state <= WAIT_LO;
`endif
                end
                WAIT_LO: begin
`ifdef LCD_TIMEOUT_EN
                    if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else if (!io.lcd_busy) begin
`else
                    if (!io.lcd_busy) begin
`endif
                        // The buffer shifts so the next char is always in the low byte.
                        if (r_addr_phase) begin
                            r_addr_phase <= 1'b0;
                            r_idx        <= '0;
                            r_state      <= ISSUE;
                        end else begin
                            r_buf <= r_buf >> 8;
                            if (r_idx == IW'(COLS - 1)) begin
                                r_state <= DONE;
                            end else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= ISSUE;
                            end
                        end
                    end
`ifdef LCD_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_done   <= r_grant ? 2'b10 : 2'b01;
                    r_active <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.done       = r_done;
    assign io.active     = r_active;
    assign io.grant_id   = r_grant;
    assign io.lcd_enable = r_lcd_enable;
    assign io.lcd_bus    = r_lcd_bus;
endmodule

// File: tb/tb_lcd_line_arbiter.sv
// tb/tb_lcd_line_arbiter.sv - directed self-checking bench for lcd_line_arbiter with a busy-pulse driver model
module tb_lcd_line_arbiter;
    localparam int COLS = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lcd_line_arbiter_if #(.COLS(COLS)) io ();

    lcd_line_arbiter #(
        .COLS(COLS)
`ifdef LCD_TIMEOUT_EN
        , .TIMEOUT(20)
`endif
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io      (io)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int done_cyc = 0;
    int done0 = 0;
    int done1 = 0;
    int bcnt = 0;
    bit busy_force = 1'b0;
    bit no_busy = 1'b0;
    bit prev_en = 1'b0;
    logic [9:0] q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*COLS-1:0] to_line(input string s);
        logic [8*COLS-1:0] r;
        for (int k = 0; k < COLS; k++)
            r[8*k +: 8] = (k < s.len()) ? s[k] : 8'h20;
        return r;
    endfunction

    function automatic logic [31:0] chr(input string s, input int k);
        byte b;
        b = s[k];
        return {22'd0, 2'b10, b};
    endfunction

    always @(posedge clk) cyc++;

    // Driver model: busy rises after each strobe and stays high for 10 cycles.
    always @(negedge clk) begin
        if (io.lcd_enable === 1'b1) begin
            check("enable_back_to_back", {31'd0, prev_en}, 32'd0);
            check("enable_while_busy", {31'd0, io.lcd_busy}, 32'd0);
            q.push_back(io.lcd_bus);
            strobe_cyc = cyc;
            if (!no_busy)
                bcnt = 10;
        end
        prev_en = (io.lcd_enable === 1'b1);
        if (io.done[0] === 1'b1) done0++;
        if (io.done[1] === 1'b1) done1++;
        if (io.done !== 2'b00) done_cyc = cyc;
        if (bcnt > 0) begin
            io.lcd_busy = 1'b1;
            bcnt--;
        end else begin
            io.lcd_busy = busy_force;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        io.req = 2'b00;
        repeat (3) tick();
        q.delete();
        done0 = 0;
        done1 = 0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_q(input int n, input int budget);
        int t;
        t = 0;
        while (q.size() < n && t < budget) begin
            tick();
            t++;
        end
        if (q.size() < n)
            check("wait_strobes", q.size(), n);
    endtask

    task automatic wait_done(input int n0, input int n1, input int budget);
        int t;
        t = 0;
        while ((done0 < n0 || done1 < n1) && t < budget) begin
            tick();
            t++;
        end
        if (done0 < n0 || done1 < n1)
            check("wait_done", {done0[15:0], done1[15:0]}, {n0[15:0], n1[15:0]});
    endtask

    initial begin
        string s_hello, s_a, s_b, s_c;
        int c0;
        s_hello = "HELLO WORLD     ";
        s_a = "ABCDEFGHIJKLMNOP";
        s_b = "line two text ok";
        s_c = "zzzzzzzzzzzzzzzz";
        io.req = 2'b00;
        io.line0 = '0;
        io.line1 = '0;
        io.lcd_busy = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();

        check("rst_enable", {31'd0, io.lcd_enable}, 32'd0);
        check("rst_bus", {22'd0, io.lcd_bus}, 32'd0);
        check("rst_done", {30'd0, io.done}, 32'd0);
        check("rst_active", {31'd0, io.active}, 32'd0);
        check("rst_err", {31'd0, io.err}, 32'd0);
        check("rst_grant", {31'd0, io.grant_id}, 32'd1);

        // Single line with first-strobe latency
        do_reset();
        io.line0 = to_line(s_hello);
        io.req = 2'b01;
        c0 = cyc;
        tick();
        check("grant_active", {31'd0, io.active}, 32'd1);
        check("grant_id0", {31'd0, io.grant_id}, 32'd0);
        io.req = 2'b00;
        tick();
        check("first_strobe_latency", strobe_cyc - c0, 32'd2);
        wait_done(1, 0, 1000);
        tick();
        check("single_count", q.size(), 32'd17);
        if (q.size() == 17) begin
            check("single_addr", {22'd0, q[0]}, 32'h080);
            for (int k = 0; k < COLS; k++)
                check("single_char", {22'd0, q[k+1]}, chr(s_hello, k));
            check("single_last", {22'd0, q[16]}, 32'h220);
        end
        check("single_done0", done0, 32'd1);
        check("single_done1", done1, 32'd0);
        check("single_idle", {31'd0, io.active}, 32'd0);

        // Latched text survives line0 change and req drop
        q.delete();
        done0 = 0;
        io.line0 = to_line(s_a);
        io.req = 2'b01;
        wait_q(5, 500);
        io.line0 = to_line(s_c);
        io.req = 2'b00;
        wait_done(1, 0, 1000);
        tick();
        check("mid_count", q.size(), 32'd17);
        if (q.size() == 17)
            for (int k = 4; k < COLS; k++)
                check("mid_char", {22'd0, q[k+1]}, chr(s_a, k));
        check("mid_done0", done0, 32'd1);

        // Reset during char 5
        q.delete();
        io.line0 = to_line(s_a);
        io.req = 2'b01;
        wait_q(7, 500);
        rst_n = 1'b0;
        io.req = 2'b00;
        tick();
        check("midrst_enable", {31'd0, io.lcd_enable}, 32'd0);
        check("midrst_active", {31'd0, io.active}, 32'd0);
        check("midrst_done", {30'd0, io.done}, 32'd0);
        check("midrst_grant", {31'd0, io.grant_id}, 32'd1);
        rst_n = 1'b1;
        repeat (40) tick();
        check("midrst_no_strobes", q.size(), 32'd7);

        // Tie right after reset: 0, then 1, then 0 again
        do_reset();
        io.line0 = to_line(s_a);
        io.line1 = to_line(s_b);
        io.req = 2'b11;
        wait_done(2, 1, 3000);
        io.req = 2'b00;
        repeat (5) tick();
        check("tie_count", q.size(), 32'd51);
        if (q.size() == 51) begin
            check("tie_first", {22'd0, q[0]}, 32'h080);
            check("tie_second", {22'd0, q[17]}, 32'h0C0);
            check("tie_line1_c0", {22'd0, q[18]}, chr(s_b, 0));
            check("tie_line1_c15", {22'd0, q[33]}, chr(s_b, 15));
            check("tie_third", {22'd0, q[34]}, 32'h080);
        end

        // Driver busy initialising
        do_reset();
        busy_force = 1'b1;
        tick();
        io.line1 = to_line(s_b);
        io.req = 2'b10;
        repeat (500) tick();
        io.req = 2'b00;
        check("busy_no_strobe", q.size(), 32'd0);
        check("busy_active", {31'd0, io.active}, 32'd1);
        busy_force = 1'b0;
        wait_done(0, 1, 1000);
        tick();
        check("busy_count", q.size(), 32'd17);
        if (q.size() > 0)
            check("busy_addr", {22'd0, q[0]}, 32'h0C0);
        check("busy_done1", done1, 32'd1);

`ifdef LCD_TIMEOUT_EN
        do_reset();
        no_busy = 1'b1;
        io.line0 = to_line(s_a);
        io.req = 2'b01;
        tick();
        io.req = 2'b00;
        wait_done(1, 0, 200);
        check("to_err", {31'd0, io.err}, 32'd1);
        check("to_latency", done_cyc - strobe_cyc, 32'd22);
        check("to_strobes", q.size(), 32'd1);
        no_busy = 1'b0;
        tick();
        io.req = 2'b01;
        tick();
        io.req = 2'b00;
        wait_done(2, 0, 1000);
        tick();
        check("to_err_sticky", {31'd0, io.err}, 32'd1);
        check("to_next_count", q.size(), 32'd18);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_line_arbiter.md
# lcd_line_arbiter

Shares one character-LCD driver between two line-update clients. Each client presents a full line of ASCII text and a request. The block arbitrates round-robin and latches the winner's line. It then streams one set-DDRAM-address command followed by COLS data writes to the LCD driver over its lcd_enable / lcd_bus / busy handshake. It sits between application logic and the LCD driver and is the only master of that driver's command port.

## Interface
- COLS, 16: characters per line; legal range 1..40.
- TIMEOUT, 4095: maximum cycles to wait on a driver busy edge; only used with LCD_TIMEOUT_EN.
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  2  per-client request level; bit 0 = line 1, bit 1 = line 2.
- line0  in  8*COLS  client 0 text; char k = line0[8k+7:8k]; char 0 is leftmost.
- line1  in  8*COLS  client 1 text; same layout.
- done  out  2  one-cycle pulse to the served client when its line transfer ends.
- active  out  1  high from grant through the final write.
- grant_id  out  1  id of the current or last granted client.
- lcd_busy  in  1  driver busy; high while initialising or executing a write.
- lcd_enable  out  1  one-cycle write strobe to the driver.
- lcd_bus  out  10  {rs, rw, data[7:0]} presented with lcd_enable.
- err  out  1  sticky timeout flag; constant 0 without LCD_TIMEOUT_EN.

## Operation
- Reset values: lcd_enable=0, lcd_bus=0, done=0, active=0, err=0, grant_id=1. With grant_id=1, client 0 wins the first tie. FSM resets to IDLE and the char index to 0.
- IDLE:
  - If any req bit is high, select the winner: a lone requester wins; on a tie, the client != grant_id wins.
  - Latch that client's line into an internal buffer, set grant_id, set active=1, and go to ISSUE with index=ADDR.
- ISSUE: hold until lcd_busy==0. In that cycle assert lcd_enable=1 with the following lcd_bus value, then go to WAIT_HI:
  - Address phase: {1'b0, 1'b0, 8'h80 | base}, where base=8'h00 for client 0 and 8'h40 for client 1.
  - Char phase k: {1'b1, 1'b0, buf[8k+7:8k]}.
- WAIT_HI: wait for lcd_busy==1, meaning the driver accepted the write. Then go to WAIT_LO.
- WAIT_LO: wait for lcd_busy==0, then advance:
  - After the address phase, set k=0.
  - After a char phase, set k=k+1.
  - If k reaches COLS, go to DONE; otherwise go to ISSUE.
- DONE: pulse done[grant_id] for one cycle, set active=0, and return to IDLE. Arbitration is next evaluated in IDLE, the cycle after DONE.
- Latched text is immune to later changes on line0/line1. Dropping req mid-transfer does not abort the transfer.
- A req still high after done re-arbitrates normally. If the other client is also requesting, the other client is served first.
- lcd_enable is never high in two consecutive cycles. It is never asserted while lcd_busy==1.
- If rst_n goes low mid-transfer, at the next edge all outputs take their reset values and the FSM enters IDLE. The partial line is abandoned.

## Timing
- Grant latency: 1 cycle (IDLE→ISSUE). The first lcd_enable comes at the earliest 2 cycles after req is sampled high, if lcd_busy==0.
- Per write: 1 ISSUE cycle + ≥1 WAIT_HI cycle + the driver's busy duration + 1 WAIT_LO exit cycle.
- Whole line: COLS+1 writes, followed by 1 DONE cycle.
- done rises 1 cycle after lcd_busy is seen low following the last char.
- Outputs are registered. lcd_bus holds its last value between strobes and is only meaningful while lcd_enable==1.

## Configuration
- LCD_TIMEOUT_EN defined:
  - A 12+-bit counter clears on entry to WAIT_HI or WAIT_LO and increments each cycle spent there.
  - If it reaches TIMEOUT, err is set sticky to 1 until reset, and the FSM jumps to DONE. done[grant_id] still pulses, so the client never hangs.
- LCD_TIMEOUT_EN undefined: no counter, WAIT states wait indefinitely, err is tied to 0.

## Test plan
- Single line: model the driver with busy=1 for 10 cycles after each strobe. Drive req=2'b01 with line0="HELLO WORLD     ". Require 17 strobes: lcd_bus=10'h080, then 10'h248 ('H'), …, with the last 10'h220. Require done=2'b01 for exactly one cycle.
- Tie: drive req=2'b11 right after reset. Require client 0 served first (address 10'h080), then client 1 (10'h0C0), then client 0 again if req[0] is still high.
- Busy at start: hold lcd_busy=1 for 500 cycles (driver initialising) and assert req=2'b10. Require lcd_enable to stay low until busy falls, then the first strobe carries 10'h0C0.
- Mid-transfer changes: change line0 and drop req[0] after char 3. Require the remaining chars to come from the originally latched text and done[0] to still pulse.
- Reset: pull rst_n low during char 5. Require lcd_enable=0, active=0, done=0 the next cycle and no further strobes until a new req.
- Timeout (LCD_TIMEOUT_EN, TIMEOUT=20): the driver never raises busy. Require err=1 and a done pulse 22 cycles after the strobe, and err to stay high through the next transfer.
